mni_sequencer: RTL and testbench

MNI_SEQUENCER -- requirements
Module: mni_sequencer

---
 rtl/mni_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mni_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mni_sequencer.sv
// Sequences decoded packets into myNodeInfo: captures fields, holds them through a
// SETUP window, pulses en_MNI for one cycle, then waits SETTLE before accepting more.
module mni_sequencer #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [2:0]  pkt_type,
  input  logic [95:0] pkt_fields,
  output logic [2:0]  fPktType,
  output logic [95:0] mni_fields,
  output logic        en_MNI,
  output logic        done,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Counter reload values: the counter runs N-1 down to 0, giving exactly N cycles.
  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_s;
  logic       xfer_s;
  logic       capture_s;
  logic       drop_s;

  function automatic logic is_forwarded(input logic [2:0] t);
    logic fwd;
    case (t)
      3'b000, 3'b001, 3'b100, 3'b101: fwd = 1'b1;
      default:                        fwd = 1'b0;
    endcase
    return fwd;
  endfunction

  assign xfer_s = pkt_valid & pkt_ready;

  // Next-state and shared down-counter logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    drop_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          if (is_forwarded(pkt_type)) begin
            capture_s = 1'b1;
            state_s   = SETUP;
            cnt_s     = SETUP_LOAD;
          end else begin
            drop_s    = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == 4'd0) begin
          state_s = ENABLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      ENABLE: begin
        state_s = SETTLE;
        cnt_s   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and registered handshake/pulse outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      pkt_ready <= 1'b0;
      en_MNI    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pkt_ready <= (state_s == IDLE);
      en_MNI    <= (state_s == ENABLE);
      done      <= (state_s == SETTLE) && (cnt_s == 4'd0);
    end
  end

  // Field capture: only a forwarded transfer updates what myNodeInfo sees.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fPktType   <= 3'b111;
      mni_fields <= 96'd0;
    end else if (capture_s) begin
      fPktType   <= pkt_type;
      mni_fields <= pkt_fields;
    end else begin
      fPktType   <= fPktType;
      mni_fields <= mni_fields;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_cnt <= 8'd0;
    end else if (drop_s && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end

  mni_sequencer_chk u_chk (
    .clk       (clk),
    .nrst      (nrst),
    .en_mni    (en_MNI),
    .done      (done),
    .in_enable (state_r == ENABLE)
  );

endmodule

// Protocol invariants on the enable and done pulses.
module mni_sequencer_chk (
  input logic clk,
  input logic nrst,
  input logic en_mni,
  input logic done,
  input logic in_enable
);

  a_no_overlap: assert property (@(posedge clk) disable iff (!nrst) !(en_mni && done));
  a_en_in_enable: assert property (@(posedge clk) disable iff (!nrst) en_mni |-> in_enable);

endmodule

// File: tb/tb_mni_sequencer.sv
// Self-checking bench for mni_sequencer: directed scenarios plus randomized traffic
// against a timing-window reference model.
module tb_mni_sequencer;

  localparam int S = 2;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [2:0]  pkt_type = 3'd0;
  logic [95:0] pkt_fields = 96'd0;
  logic [2:0]  fPktType;
  logic [95:0] mni_fields;
  logic        en_MNI;
  logic        done;
  logic [7:0]  drop_cnt;

  mni_sequencer #(.SETUP_CYC(S), .SETTLE_CYC(T)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_type   (pkt_type),
    .pkt_fields (pkt_fields),
    .fPktType   (fPktType),
    .mni_fields (mni_fields),
    .en_MNI     (en_MNI),
    .done       (done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  // Reference model: remembers the acceptance edge and derives every output from it.
  bit          m_ready;
  bit          m_en;
  bit          m_done;
  logic [2:0]  m_type;
  logic [95:0] m_fields;
  int          m_drop;
  int          acc_edge;
  int          idle_from;

  localparam logic [95:0] HB_F = {16'h0000, 16'h4000, 16'h8000, 16'h8000, 16'h0001, 16'h0000};

  function automatic logic [95:0] rand_fields();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  function automatic bit fwd_type(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd1) || (t == 3'd4) || (t == 3'd5);
  endfunction

  task automatic model_reset();
    m_ready   = 1'b0;
    m_en      = 1'b0;
    m_done    = 1'b0;
    m_type    = 3'b111;
    m_fields  = 96'd0;
    m_drop    = 0;
    acc_edge  = -1000;
    idle_from = -1;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, sample after it.
  task automatic cycle(input logic v, input logic [2:0] t, input logic [95:0] f);
    int e;
    pkt_valid  = v;
    pkt_type   = t;
    pkt_fields = f;
    e = edge_n + 1;
    if (v && m_ready) begin
      if (fwd_type(t)) begin
        acc_edge  = e;
        idle_from = e + S + T + 1;
        m_type    = t;
        m_fields  = f;
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    m_ready = (e >= idle_from);
    m_en    = (e == acc_edge + S);
    m_done  = (e == acc_edge + S + T);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    model_reset();
    #1 nrst = 1'b0;
    #1;
    checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", pkt_ready); end
    checks++; if (en_MNI !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", en_MNI); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (fPktType !== 3'b111) begin errors++; $display("FAIL reset_type: got %b want 111", fPktType); end
    checks++; if (mni_fields !== 96'd0) begin errors++; $display("FAIL reset_fields: got %h want 0", mni_fields); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    @(negedge clk);
    nrst = 1'b1;
    cycle(1'b0, 3'd0, 96'd0);
    checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", pkt_ready); end
  endtask

  task automatic test_hb();
    cycle(1'b1, 3'd0, HB_F);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) cycle(1'b0, 3'd0, 96'd0);
      checks++; if (en_MNI !== (k == 3)) begin errors++; $display("FAIL hb_en k=%0d: got %b want %b", k, en_MNI, (k == 3)); end
      checks++; if (done !== (k == 7)) begin errors++; $display("FAIL hb_done k=%0d: got %b want %b", k, done, (k == 7)); end
      checks++; if (pkt_ready !== (k == 8)) begin errors++; $display("FAIL hb_ready k=%0d: got %b want %b", k, pkt_ready, (k == 8)); end
    end
    checks++; if (fPktType !== 3'b000) begin errors++; $display("FAIL hb_type: got %b want 000", fPktType); end
    checks++; if (mni_fields !== HB_F) begin errors++; $display("FAIL hb_fields: got %h want %h", mni_fields, HB_F); end
  endtask

  task automatic test_drop();
    cycle(1'b1, 3'b010, rand_fields());
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_first: got %0d want 1", drop_cnt); end
    checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL drop_ready1: got %b want 1", pkt_ready); end
    checks++; if (en_MNI !== 1'b0) begin errors++; $display("FAIL drop_en1: got %b want 0", en_MNI); end
    cycle(1'b1, 3'b111, rand_fields());
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_second: got %0d want 2", drop_cnt); end
    checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL drop_ready2: got %b want 1", pkt_ready); end
    cycle(1'b0, 3'd0, 96'd0);
    checks++; if (en_MNI !== 1'b0) begin errors++; $display("FAIL drop_en2: got %b want 0", en_MNI); end
    checks++; if (fPktType !== 3'b000) begin errors++; $display("FAIL drop_type: got %b want 000", fPktType); end
    checks++; if (mni_fields !== HB_F) begin errors++; $display("FAIL drop_fields: got %h want %h", mni_fields, HB_F); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] che_f;
    logic [95:0] dat_f;
    int a1;
    int a2;
    int pulses;
    bit acc;
    che_f = rand_fields(); che_f[15:0] = 16'h000C;
    dat_f = rand_fields(); dat_f[15:0] = 16'd14;
    cycle(1'b1, 3'b001, che_f);
    a1 = edge_n;
    a2 = -1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      acc = (a2 < 0) && (pkt_ready === 1'b1);
      cycle((a2 < 0) ? 1'b1 : 1'b0, 3'b101, dat_f);
      if (acc) a2 = edge_n;
      if (en_MNI === 1'b1) begin
        pulses++;
        checks++;
        if (pulses == 1) begin
          if (fPktType !== 3'b001 || mni_fields !== che_f) begin
            errors++; $display("FAIL b2b_che_hold: got %b/%h want 001/%h", fPktType, mni_fields, che_f);
          end
        end else begin
          if (fPktType !== 3'b101 || mni_fields !== dat_f) begin
            errors++; $display("FAIL b2b_data_hold: got %b/%h want 101/%h", fPktType, mni_fields, dat_f);
          end
        end
      end
    end
    checks++; if (a2 - a1 !== 8) begin errors++; $display("FAIL b2b_spacing: got %0d want 8", a2 - a1); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
  endtask

  task automatic test_mid_reset();
    logic [95:0] cs_f;
    int en_k;
    int done_k;
    cs_f = rand_fields(); cs_f[95:80] = 16'd5;
    cycle(1'b1, 3'b100, cs_f);
    for (int k = 2; k <= 5; k++) cycle(1'b0, 3'd0, 96'd0);
    checks++; if (fPktType !== 3'b100) begin errors++; $display("FAIL mid_type_pre: got %b want 100", fPktType); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (en_MNI !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_pulses: got en=%b done=%b want 0 0", en_MNI, done); end
    checks++; if (pkt_ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", pkt_ready); end
    checks++; if (fPktType !== 3'b111 || mni_fields !== 96'd0) begin errors++; $display("FAIL mid_capture: got %b/%h want 111/0", fPktType, mni_fields); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", drop_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; edge_n++;
      checks++; if (done !== 1'b0 || en_MNI !== 1'b0) begin errors++; $display("FAIL mid_hold: got en=%b done=%b want 0 0", en_MNI, done); end
    end
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    cycle(1'b0, 3'd0, 96'd0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", done); end
    cycle(1'b1, 3'd0, HB_F);
    en_k = 0;
    done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) cycle(1'b0, 3'd0, 96'd0);
      if (en_MNI === 1'b1) en_k = en_k * 10 + k;
      if (done === 1'b1) done_k = done_k * 10 + k;
    end
    checks++; if (en_k !== 3) begin errors++; $display("FAIL mid_hb_en_cycle: got %0d want 3", en_k); end
    checks++; if (done_k !== 7) begin errors++; $display("FAIL mid_hb_done_cycle: got %0d want 7", done_k); end
  endtask

  task automatic test_saturation();
    int not_ready;
    int pulses;
    not_ready = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 3'b011, rand_fields());
      if (pkt_ready !== 1'b1) not_ready++;
    end
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_drop: got %h want ff", drop_cnt); end
    checks++; if (not_ready !== 0) begin errors++; $display("FAIL sat_ready: got %0d stalls want 0", not_ready); end
    cycle(1'b1, 3'b101, rand_fields());
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 3'd0, 96'd0);
      if (en_MNI === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL sat_fwd_pulses: got %0d want 1", pulses); end
    checks++; if (drop_cnt !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %h want ff", drop_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        #2 nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
      end
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rand_fields());
      checks++; if (pkt_ready !== m_ready) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", edge_n, pkt_ready, m_ready); end
      checks++; if (en_MNI !== m_en) begin errors++; $display("FAIL rnd_en @%0d: got %b want %b", edge_n, en_MNI, m_en); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done @%0d: got %b want %b", edge_n, done, m_done); end
      checks++; if (fPktType !== m_type) begin errors++; $display("FAIL rnd_type @%0d: got %b want %b", edge_n, fPktType, m_type); end
      checks++; if (mni_fields !== m_fields) begin errors++; $display("FAIL rnd_fields @%0d: got %h want %h", edge_n, mni_fields, m_fields); end
      checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop @%0d: got %0d want %0d", edge_n, drop_cnt, m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_hb();
    test_drop();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
